// File: rtl/dff_sync_rst_if.sv
// Data/enable bundle for dff_sync_rst: the master drives en/d, the register drives q/q_taps/primed.
interface dff_sync_rst_if #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
);
    logic                      en;
    logic [WIDTH-1:0]          d;
    logic [WIDTH-1:0]          q;
    logic [WIDTH*STAGES-1:0]   q_taps;
    logic                      primed;

    modport master (
        output en,
        output d,
        input  q,
        input  q_taps,
        input  primed
    );

    modport slave (
        input  en,
        input  d,
        output q,
        output q_taps,
        output primed
    );
endinterface

// File: rtl/dff_sync_rst.sv
// Parameterizable D register / short delay line with clock enable, synchronous
// active-high reset and a "primed" flag that rises once every stage holds live data.
module dff_sync_rst #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    dff_sync_rst_if.slave      bus
);

    localparam int unsigned CNT_W = $clog2(STAGES + 1);

    // Reject degenerate geometries at elaboration time.
    if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
        $error("dff_sync_rst: WIDTH and STAGES must both be >= 1");
    end

    logic [WIDTH-1:0] r_stage [STAGES];
    logic [CNT_W-1:0] r_fill;
    logic             r_primed;
    logic [CNT_W-1:0] w_fill_nxt;

    // Fill count after one more enabled edge, saturating at full depth.
    always_comb begin
        w_fill_nxt = r_fill;
        if (r_fill != CNT_W'(STAGES)) begin
            w_fill_nxt = r_fill + CNT_W'(1);
        end
    end

    // Shift register and fill tracking: reset beats enable, enable beats hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= RST_VAL;
            end
            r_fill   <= '0;
            r_primed <= 1'b0;
        end else if (bus.en) begin
            r_stage[0] <= bus.d;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_fill   <= w_fill_nxt;
            r_primed <= (w_fill_nxt == CNT_W'(STAGES));
        end
    end

    // Every tap comes straight from a stage flop; q is simply the last tap.
    for (genvar g = 0; g < STAGES; g++) begin : g_taps
        assign bus.q_taps[g*WIDTH +: WIDTH] = r_stage[g];
    end

    assign bus.q      = r_stage[STAGES-1];
    assign bus.primed = r_primed;

endmodule

// File: tb/tb_dff_sync_rst.sv
// Directed scoreboard bench for dff_sync_rst: a 4-bit single-stage register and an
// 8-bit three-stage delay line with RST_VAL=8'hA5, sharing one 10 ns clock.
module tb_dff_sync_rst;

    logic clk = 1'b0;
    logic a_rst;
    logic b_rst;

    int checks   = 0;
    int failures = 0;

    // Scoreboards: front entry is the value expected on q, later entries are
    // the upstream stages in order, so the queue length equals the depth.
    logic [3:0] qa [$];
    logic [7:0] qb [$];
    int         a_cnt;
    int         b_cnt;

    dff_sync_rst_if #(.WIDTH(4), .STAGES(1)) a_if ();
    dff_sync_rst_if #(.WIDTH(8), .STAGES(3)) b_if ();

    dff_sync_rst #(.WIDTH(4), .STAGES(1), .RST_VAL(4'h0)) u_a (
        .clk (clk),
        .rst (a_rst),
        .bus (a_if)
    );

    dff_sync_rst #(.WIDTH(8), .STAGES(3), .RST_VAL(8'hA5)) u_b (
        .clk (clk),
        .rst (b_rst),
        .bus (b_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_model_reset();
        qa.delete();
        qa.push_back(4'h0);
        a_cnt = 0;
    endtask

    task automatic b_model_reset();
        qb.delete();
        repeat (3) qb.push_back(8'hA5);
        b_cnt = 0;
    endtask

    task automatic a_check(input string tag);
        chk({tag, "_q"},      64'(a_if.q),      64'(qa[0]));
        chk({tag, "_taps"},   64'(a_if.q_taps), 64'(qa[0]));
        chk({tag, "_primed"}, 64'(a_if.primed), 64'(a_cnt >= 1));
    endtask

    task automatic b_check(input string tag);
        chk({tag, "_q"},      64'(b_if.q),      64'(qb[0]));
        chk({tag, "_taps"},   64'(b_if.q_taps), 64'({qb[0], qb[1], qb[2]}));
        chk({tag, "_primed"}, 64'(b_if.primed), 64'(b_cnt >= 3));
    endtask

    // One clock of the 4-bit register: drive at negedge, check 1 ns after posedge.
    task automatic a_step(input logic en, input logic [3:0] d, input string tag);
        logic [3:0] gone;
        @(negedge clk);
        a_rst    = 1'b0;
        a_if.en  = en;
        a_if.d   = d;
        if (en) begin
            qa.push_back(d);
            gone = qa.pop_front();
            if (a_cnt < 1) a_cnt++;
        end
        @(posedge clk);
        #1;
        a_check(tag);
    endtask

    // One clock of the 3-stage line.
    task automatic b_step(input logic en, input logic [7:0] d, input string tag);
        logic [7:0] gone;
        @(negedge clk);
        b_rst    = 1'b0;
        b_if.en  = en;
        b_if.d   = d;
        if (en) begin
            qb.push_back(d);
            gone = qb.pop_front();
            if (b_cnt < 3) b_cnt++;
        end
        @(posedge clk);
        #1;
        b_check(tag);
    endtask

    initial begin
        // Both instances start in reset with en high and d all ones.
        a_rst   = 1'b1;
        a_if.en = 1'b1;
        a_if.d  = 4'hF;
        b_rst   = 1'b1;
        b_if.en = 1'b1;
        b_if.d  = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        a_model_reset();
        b_model_reset();
        a_check("a_reset");
        b_check("b_reset");

        // First edge after release captures d with no dead cycle.
        a_step(1'b1, 4'hF, "a_release");

        // Re-reset, then ramp d by 2 each cycle including the E->0 wrap.
        @(negedge clk);
        a_rst   = 1'b1;
        a_if.en = 1'b1;
        a_if.d  = 4'hF;
        @(posedge clk);
        #1;
        a_model_reset();
        a_check("a_rereset");
        for (int i = 0; i < 10; i++) begin
            a_step(1'b1, 4'(2 * i), $sformatf("a_ramp%0d", i));
        end

        // Enable low freezes q while d toggles; raising en resumes capture.
        a_step(1'b1, 4'h6, "a_load6");
        for (int i = 0; i < 5; i++) begin
            a_step(1'b0, (i % 2 == 0) ? 4'h5 : 4'hA, $sformatf("a_hold%0d", i));
        end
        a_step(1'b1, 4'h9, "a_resume");
        a_step(1'b0, 4'h3, "a_idle");

        // Three-stage line: rst and en together with d=FF, reset must win.
        @(negedge clk);
        b_rst   = 1'b1;
        b_if.en = 1'b1;
        b_if.d  = 8'hFF;
        @(posedge clk);
        #1;
        b_model_reset();
        b_check("b_prio");

        // Fill: q shows the first sample on the third enabled edge, primed with it.
        b_step(1'b1, 8'h01, "b_fill1");
        b_step(1'b1, 8'h02, "b_fill2");
        b_step(1'b1, 8'h03, "b_fill3");
        b_step(1'b1, 8'h04, "b_fill4");

        // Reset glitch that never spans a rising edge changes nothing.
        #1;
        b_rst = 1'b1;
        #2;
        b_rst = 1'b0;
        b_step(1'b0, 8'h77, "b_glitch");

        // Reset asserted mid-run: q holds until the edge, then all taps return to A5.
        @(negedge clk);
        b_rst   = 1'b1;
        b_if.en = 1'b1;
        b_if.d  = 8'hFF;
        #1;
        chk("b_prerst_q", 64'(b_if.q), 64'(qb[0]));
        @(posedge clk);
        #1;
        b_model_reset();
        b_check("b_midrst");

        // Refill takes three more enabled edges.
        b_step(1'b1, 8'h11, "b_refill1");
        b_step(1'b1, 8'h22, "b_refill2");
        b_step(1'b1, 8'h33, "b_refill3");
        b_step(1'b0, 8'h44, "b_refill_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
